// File: rtl/vline_fetch.sv
// Line-buffer fill engine: fetches PSIZE pixels from memory starting at
// LineBase and writes them into buffer slots 0..PSIZE-1.
module vline_fetch #(
  parameter int unsigned AWIDTH  = 2,
  parameter int unsigned BPP     = 6,
  parameter int unsigned PSIZE   = 4,
  parameter int unsigned MAWIDTH = 16
) (
  input  logic               Clk,
  input  logic               nReset,
  input  logic               LineStart,
  input  logic [MAWIDTH-1:0] LineBase,
  output logic               MemReq,
  output logic [MAWIDTH-1:0] MemAddress,
  input  logic               MemAck,
  input  logic [BPP-1:0]     MemData,
  output logic               Write,
  output logic [AWIDTH-1:0]  WriteAddress,
  output logic [BPP-1:0]     WriteData,
  output logic               Busy,
  output logic               Done,
  output logic               Overrun
);

  localparam logic [AWIDTH-1:0] LAST_PIX = AWIDTH'(PSIZE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic [AWIDTH-1:0]    count, count_nxt;
  logic                 req_nxt;
  logic [MAWIDTH-1:0]   addr_nxt;
  logic                 write_nxt;
  logic [AWIDTH-1:0]    waddr_nxt;
  logic [BPP-1:0]       wdata_nxt;
  logic                 busy_nxt;
  logic                 done_nxt;
  logic                 overrun_nxt;

  // State and registered outputs; reset abandons any fill in progress.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state        <= IDLE;
      count        <= '0;
      MemReq       <= 1'b0;
      MemAddress   <= '0;
      Write        <= 1'b0;
      WriteAddress <= '0;
      WriteData    <= '0;
      Busy         <= 1'b0;
      Done         <= 1'b0;
      Overrun      <= 1'b0;
    end else begin
      state        <= state_nxt;
      count        <= count_nxt;
      MemReq       <= req_nxt;
      MemAddress   <= addr_nxt;
      Write        <= write_nxt;
      WriteAddress <= waddr_nxt;
      WriteData    <= wdata_nxt;
      Busy         <= busy_nxt;
      Done         <= done_nxt;
      Overrun      <= overrun_nxt;
    end
  end

  // Next-state and next-output decode; pulses default low, data holds.
  always_comb begin
    state_nxt   = state;
    count_nxt   = count;
    req_nxt     = MemReq;
    addr_nxt    = MemAddress;
    write_nxt   = 1'b0;
    waddr_nxt   = WriteAddress;
    wdata_nxt   = WriteData;
    busy_nxt    = Busy;
    done_nxt    = 1'b0;
    overrun_nxt = 1'b0;

    case (state)
      IDLE: begin
        if (LineStart) begin
          state_nxt = FETCH;
          req_nxt   = 1'b1;
          addr_nxt  = LineBase;
          count_nxt = '0;
          busy_nxt  = 1'b1;
        end
      end
      FETCH: begin
        overrun_nxt = LineStart;
        if (MemAck) begin
          write_nxt = 1'b1;
          waddr_nxt = count;
          wdata_nxt = MemData;
          addr_nxt  = MemAddress + MAWIDTH'(1);
          if (count == LAST_PIX) begin
            // Last pixel: drop the request on the same edge, park count at 0
            state_nxt = DONE;
            req_nxt   = 1'b0;
            count_nxt = '0;
          end else begin
            count_nxt = count + AWIDTH'(1);
          end
        end
      end
      DONE: begin
        overrun_nxt = LineStart;
        done_nxt    = 1'b1;
        busy_nxt    = 1'b0;
        state_nxt   = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_vline_fetch.sv
// Scoreboard bench for vline_fetch: stimulus queues expected pixels, a
// negedge monitor plays the memory and checks every write and request.
module tb_vline_fetch;

  logic        Clk = 1'b0;
  logic        nReset;
  logic        LineStart, LineStart3;
  logic [15:0] LineBase, LineBase3;
  logic        MemReq, MemReq3;
  logic [15:0] MemAddress, MemAddress3;
  logic        MemAck, MemAck3;
  logic [5:0]  MemData, MemData3;
  logic        Write, Write3;
  logic [1:0]  WriteAddress, WriteAddress3;
  logic [5:0]  WriteData, WriteData3;
  logic        Busy, Busy3, Done, Done3, Overrun, Overrun3;

  vline_fetch #(.AWIDTH(2), .BPP(6), .PSIZE(4), .MAWIDTH(16)) dut (
    .Clk(Clk), .nReset(nReset), .LineStart(LineStart), .LineBase(LineBase),
    .MemReq(MemReq), .MemAddress(MemAddress), .MemAck(MemAck), .MemData(MemData),
    .Write(Write), .WriteAddress(WriteAddress), .WriteData(WriteData),
    .Busy(Busy), .Done(Done), .Overrun(Overrun)
  );

  vline_fetch #(.AWIDTH(2), .BPP(6), .PSIZE(3), .MAWIDTH(16)) dut3 (
    .Clk(Clk), .nReset(nReset), .LineStart(LineStart3), .LineBase(LineBase3),
    .MemReq(MemReq3), .MemAddress(MemAddress3), .MemAck(MemAck3), .MemData(MemData3),
    .Write(Write3), .WriteAddress(WriteAddress3), .WriteData(WriteData3),
    .Busy(Busy3), .Done(Done3), .Overrun(Overrun3)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [15:0] ma;
    logic [1:0]  wa;
    logic [5:0]  d;
  } px_t;

  // Written only by stimulus
  px_t exp_q[$];
  px_t exp3_q[$];
  int  stall_cfg = 0;
  int  done_exp = 0, ov_exp = 0, done3_exp = 0;
  int  end_req = 0;

  // Written only by the monitor
  int  checks = 0, errors = 0;
  int  r_idx = 0, w_idx = 0, r3_idx = 0, w3_idx = 0;
  int  stall_cnt = 0, w_cnt = 0;
  int  done_got = 0, ov_got = 0, done3_got = 0;
  int  end_seen = 0;
  logic ack_prev = 1'b0, wr_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor and memory model, sampled on the falling edge
  always @(negedge Clk) begin
    if (!nReset) begin
      chk("rst_memreq", 32'(MemReq), 0);
      chk("rst_memaddr", 32'(MemAddress), 0);
      chk("rst_write", 32'(Write), 0);
      chk("rst_waddr", 32'(WriteAddress), 0);
      chk("rst_wdata", 32'(WriteData), 0);
      chk("rst_busy", 32'(Busy), 0);
      chk("rst_done", 32'(Done), 0);
      chk("rst_overrun", 32'(Overrun), 0);
      r_idx = exp_q.size();  w_idx = exp_q.size();
      r3_idx = exp3_q.size(); w3_idx = exp3_q.size();
      stall_cnt = 0; ack_prev = 1'b0; wr_prev = 1'b0;
      MemAck = 1'b0; MemAck3 = 1'b0;
    end else begin
      chk("wr_latency", 32'(Write), 32'(ack_prev));
      if (Write) begin
        w_cnt++;
        if (w_idx < exp_q.size()) begin
          chk("wr_addr", 32'(WriteAddress), 32'(exp_q[w_idx].wa));
          chk("wr_data", 32'(WriteData), 32'(exp_q[w_idx].d));
          w_idx++;
        end else begin
          chk("extra_write", 32'(w_idx), 32'(exp_q.size()));
        end
      end
      if (Done) begin
        chk("done_after_last_write", 32'(wr_prev), 1);
        chk("busy_low_at_done", 32'(Busy), 0);
        done_got++;
      end
      if (Overrun) ov_got++;
      wr_prev = Write;

      MemAck = 1'b0;
      if (MemReq) begin
        chk("busy_with_req", 32'(Busy), 1);
        if (r_idx < exp_q.size()) begin
          chk("mem_addr", 32'(MemAddress), 32'(exp_q[r_idx].ma));
          if (stall_cnt >= stall_cfg) begin
            MemAck = 1'b1;
            MemData = exp_q[r_idx].d;
            r_idx++;
            stall_cnt = 0;
          end else begin
            stall_cnt++;
          end
        end else begin
          chk("unexpected_req", 32'(r_idx), 32'(exp_q.size()));
        end
      end
      ack_prev = MemAck;

      if (Write3) begin
        if (w3_idx < exp3_q.size()) begin
          chk("p3_wr_addr", 32'(WriteAddress3), 32'(exp3_q[w3_idx].wa));
          chk("p3_wr_data", 32'(WriteData3), 32'(exp3_q[w3_idx].d));
          w3_idx++;
        end else begin
          chk("p3_extra_write", 32'(w3_idx), 32'(exp3_q.size()));
        end
      end
      if (Done3) done3_got++;
      MemAck3 = 1'b0;
      if (MemReq3) begin
        if (r3_idx < exp3_q.size()) begin
          chk("p3_mem_addr", 32'(MemAddress3), 32'(exp3_q[r3_idx].ma));
          MemAck3 = 1'b1;
          MemData3 = exp3_q[r3_idx].d;
          r3_idx++;
        end else begin
          chk("p3_unexpected_req", 32'(r3_idx), 32'(exp3_q.size()));
        end
      end
    end

    if (end_req != end_seen) begin
      end_seen = end_req;
      chk("all_writes_seen", 32'(w_idx), 32'(exp_q.size()));
      chk("all_reads_seen", 32'(r_idx), 32'(exp_q.size()));
      chk("done_count", 32'(done_got), 32'(done_exp));
      chk("overrun_count", 32'(ov_got), 32'(ov_exp));
      chk("p3_all_writes_seen", 32'(w3_idx), 32'(exp3_q.size()));
      chk("p3_done_count", 32'(done3_got), 32'(done3_exp));
    end
  end

  task automatic push4(input logic [15:0] m0, m1, m2, m3,
                       input logic [5:0] d0, d1, d2, d3);
    exp_q.push_back('{ma: m0, wa: 2'd0, d: d0});
    exp_q.push_back('{ma: m1, wa: 2'd1, d: d1});
    exp_q.push_back('{ma: m2, wa: 2'd2, d: d2});
    exp_q.push_back('{ma: m3, wa: 2'd3, d: d3});
  endtask

  task automatic pulse_start(input logic [15:0] base);
    @(posedge Clk); #2;
    LineStart = 1'b1; LineBase = base;
    @(posedge Clk); #2;
    LineStart = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_got < target && n < 300) begin
      @(posedge Clk); n++;
    end
    if (n >= 300) $display("FAIL timeout_done got=%0d required=%0d", done_got, target);
  endtask

  task automatic end_test();
    repeat (3) @(posedge Clk);
    #2 end_req++;
    @(negedge Clk); #1;
  endtask

  initial begin
    int n;
    int base_w;
    nReset = 1'b0; LineStart = 1'b0; LineBase = '0;
    LineStart3 = 1'b0; LineBase3 = '0;
    MemAck = 1'b0; MemData = '0; MemAck3 = 1'b0; MemData3 = '0;
    repeat (3) @(posedge Clk);
    #2 nReset = 1'b1;

    // Back-to-back fill
    stall_cfg = 0;
    push4(16'h0100, 16'h0101, 16'h0102, 16'h0103, 6'h01, 6'h02, 6'h03, 6'h04);
    done_exp++;
    pulse_start(16'h0100);
    wait_done(done_exp);
    end_test();

    // Three-cycle stall before each pixel
    stall_cfg = 3;
    push4(16'h0200, 16'h0201, 16'h0202, 16'h0203, 6'h11, 6'h22, 6'h33, 6'h3F);
    done_exp++;
    pulse_start(16'h0200);
    wait_done(done_exp);
    end_test();

    // Address wrap through all-ones
    stall_cfg = 0;
    push4(16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001, 6'h2A, 6'h15, 6'h00, 6'h3F);
    done_exp++;
    pulse_start(16'hFFFE);
    wait_done(done_exp);
    end_test();

    // LineStart during FETCH is rejected with Overrun
    stall_cfg = 2;
    push4(16'h0300, 16'h0301, 16'h0302, 16'h0303, 6'h05, 6'h06, 6'h07, 6'h08);
    done_exp++;
    ov_exp++;
    pulse_start(16'h0300);
    @(posedge Clk); #2;
    LineStart = 1'b1; LineBase = 16'h5555;
    @(posedge Clk); #2;
    LineStart = 1'b0;
    wait_done(done_exp);
    end_test();

    // Reset after two writes, then a fresh fill
    stall_cfg = 1;
    base_w = w_cnt;
    push4(16'h0400, 16'h0401, 16'h0402, 16'h0403, 6'h09, 6'h0A, 6'h0B, 6'h0C);
    pulse_start(16'h0400);
    n = 0;
    while (w_cnt < base_w + 2 && n < 300) begin
      @(negedge Clk); n++;
    end
    if (n >= 300) $display("FAIL timeout_two_writes got=%0d required=%0d", w_cnt - base_w, 2);
    @(posedge Clk); #2 nReset = 1'b0;
    @(negedge Clk); #1;
    @(posedge Clk); #2 nReset = 1'b1;
    stall_cfg = 0;
    push4(16'h0500, 16'h0501, 16'h0502, 16'h0503, 6'h21, 6'h22, 6'h23, 6'h24);
    done_exp++;
    pulse_start(16'h0500);
    wait_done(done_exp);
    end_test();

    // Non-power-of-two line length
    exp3_q.push_back('{ma: 16'h0010, wa: 2'd0, d: 6'h31});
    exp3_q.push_back('{ma: 16'h0011, wa: 2'd1, d: 6'h32});
    exp3_q.push_back('{ma: 16'h0012, wa: 2'd2, d: 6'h33});
    done3_exp++;
    @(posedge Clk); #2;
    LineStart3 = 1'b1; LineBase3 = 16'h0010;
    @(posedge Clk); #2;
    LineStart3 = 1'b0;
    n = 0;
    while (done3_got < done3_exp && n < 300) begin
      @(posedge Clk); n++;
    end
    if (n >= 300) $display("FAIL timeout_p3_done got=%0d required=%0d", done3_got, done3_exp);
    end_test();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
